// File: rtl/fp_status_accumulator.sv
// Status-byte accumulator for the FP multiplier: sticky exception flags, saturating
// per-flag and total event counters, snapshot shadows with host read port, and a masked irq.
module fp_status_accumulator #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       status,
  input  logic             clr,
  input  logic             snap,
  input  logic [5:0]       irq_mask,
  input  logic             rd_en,
  input  logic [2:0]       rd_addr,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic [5:0]       sticky,
  output logic             viol,
  output logic             irq
);

  localparam int NUM_FLAGS = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ADDR_FLAGS = 3'd6,
    ADDR_TOTAL = 3'd7
  } rd_addr_e;

  logic [CNT_W-1:0] cnt        [NUM_FLAGS];
  logic [CNT_W-1:0] cnt_next   [NUM_FLAGS];
  logic [CNT_W-1:0] shadow     [NUM_FLAGS];
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] total_next;
  logic [CNT_W-1:0] shadow_total;
  logic [5:0]       sticky_next;
  logic             viol_next;
  logic             illegal;
  logic [CNT_W-1:0] rd_mux;

  logic zero, inf, nan, tiny, huge;
  assign zero = status[0];
  assign inf  = status[1];
  assign nan  = status[2];
  assign tiny = status[3];
  assign huge = status[4];

  // A value cannot be both zero and non-finite/overflowed, nor tiny and non-finite/overflowed.
  assign illegal = (|status[7:6])
                 | (zero & (inf | nan | huge))
                 | (tiny & (inf | nan | huge));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // clr is applied to the base value first, so a same-cycle sample lands on a cleared state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    sticky_next = clr ? 6'b0 : sticky;
    viol_next   = clr ? 1'b0 : viol;
    total_next  = clr ? '0 : total;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      cnt_next[i] = clr ? '0 : cnt[i];
    end
    if (in_valid) begin
      sticky_next = sticky_next | status[5:0];
      viol_next   = viol_next | illegal;
      total_next  = sat_inc(total_next);
      for (int i = 0; i < NUM_FLAGS; i++) begin
        if (status[i]) cnt_next[i] = sat_inc(cnt_next[i]);
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      ADDR_FLAGS: rd_mux[6:0] = {viol, sticky};
      ADDR_TOTAL: rd_mux      = shadow_total;
      default:    rd_mux      = shadow[rd_addr];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the counter and shadow arrays are small flop banks, not RAM, so they are reset like any other register.
      for (int i = 0; i < NUM_FLAGS; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
      total        <= '0;
      shadow_total <= '0;
      sticky       <= '0;
      viol         <= 1'b0;
      irq          <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make snap, read and irq all see the pre-edge values.
      for (int i = 0; i < NUM_FLAGS; i++) begin
        cnt[i] <= cnt_next[i];
      end
      total  <= total_next;
      sticky <= sticky_next;
      viol   <= viol_next;
      irq    <= |(sticky & irq_mask);
      if (snap) begin
        for (int i = 0; i < NUM_FLAGS; i++) begin
          shadow[i] <= cnt[i];
        end
        shadow_total <= total;
      end
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_fp_status_accumulator.sv
// Directed bench for fp_status_accumulator (CNT_W=8 so saturation is reachable quickly).
module tb_fp_status_accumulator;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [7:0]       status;
  logic             clr;
  logic             snap;
  logic [5:0]       irq_mask;
  logic             rd_en;
  logic [2:0]       rd_addr;
  logic [CNT_W-1:0] rd_data;
  logic             rd_valid;
  logic [5:0]       sticky;
  logic             viol;
  logic             irq;

  int checks   = 0;
  int failures = 0;

  fp_status_accumulator #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .status   (status),
    .clr      (clr),
    .snap     (snap),
    .irq_mask (irq_mask),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .sticky   (sticky),
    .viol     (viol),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] s, input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      status   = s;
      tick();
    end
    in_valid = 1'b0;
    status   = 8'h00;
  endtask

  task automatic pulse_snap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic read(input logic [2:0] addr, input logic [31:0] expected, input string tag);
    rd_en   = 1'b1;
    rd_addr = addr;
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, {31'b0, rd_valid}, 32'd1);
    check(tag, {24'b0, rd_data}, expected);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; status = 8'h00; clr = 1'b0; snap = 1'b0;
    irq_mask = 6'h00; rd_en = 1'b0; rd_addr = 3'd0;
    #2;
    check("rst_sticky", {26'b0, sticky}, 32'h0);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    #10 rst_n = 1'b1;
    tick();

    // Build up nonzero state, then reset asynchronously mid-cycle with a read pending.
    irq_mask = 6'h3f;
    sample(8'h03, 1);
    tick();
    check("pre_rst_irq", {31'b0, irq}, 32'h1);
    read(3'd6, 32'h43, "pre_rst_rd6");
    rd_en = 1'b1; rd_addr = 3'd6;
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_sticky", {26'b0, sticky}, 32'h0);
    check("async_rst_viol", {31'b0, viol}, 32'h0);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    check("async_rst_rd_data", {24'b0, rd_data}, 32'h0);
    check("async_rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    rd_en = 1'b0; irq_mask = 6'h00;
    #2 rst_n = 1'b1;
    tick();
    read(3'd7, 32'h0, "post_rst_rd7");

    // Accumulate.
    sample(8'h01, 3);
    sample(8'h24, 1);
    pulse_snap();
    check("acc_viol", {31'b0, viol}, 32'h0);
    check("acc_sticky", {26'b0, sticky}, 32'h25);
    read(3'd0, 32'd3, "acc_rd0");
    read(3'd1, 32'd0, "acc_rd1");
    read(3'd2, 32'd1, "acc_rd2");
    read(3'd5, 32'd1, "acc_rd5");
    read(3'd6, 32'h25, "acc_rd6");
    read(3'd7, 32'd4, "acc_rd7");
    tick();
    check("rd_valid_drop", {31'b0, rd_valid}, 32'h0);
    check("rd_data_hold", {24'b0, rd_data}, 32'd4);

    // Read in the same cycle as snap returns the pre-snap shadow.
    sample(8'h01, 1);
    snap = 1'b1; rd_en = 1'b1; rd_addr = 3'd0;
    tick();
    snap = 1'b0; rd_en = 1'b0;
    check("snap_rd_same", {24'b0, rd_data}, 32'd3);
    read(3'd0, 32'd4, "snap_rd_after");

    // Violation.
    pulse_clr();
    sample(8'h03, 1);
    check("viol_set", {31'b0, viol}, 32'h1);
    sample(8'h48, 1);
    tick(); tick();
    check("viol_sticky", {31'b0, viol}, 32'h1);
    pulse_snap();
    read(3'd0, 32'd1, "viol_rd0");
    read(3'd1, 32'd1, "viol_rd1");
    read(3'd3, 32'd1, "viol_rd3");
    read(3'd7, 32'd2, "viol_rd7");
    pulse_clr();
    check("viol_clr", {31'b0, viol}, 32'h0);

    // Saturation.
    sample(8'h01, 300);
    pulse_snap();
    read(3'd0, 32'd255, "sat_rd0");
    read(3'd7, 32'd255, "sat_rd7");

    // Read-and-clear.
    pulse_clr();
    sample(8'h02, 5);
    snap = 1'b1; clr = 1'b1;
    tick();
    snap = 1'b0; clr = 1'b0;
    check("rc_sticky", {26'b0, sticky}, 32'h0);
    read(3'd1, 32'd5, "rc_rd1");
    pulse_snap();
    read(3'd1, 32'd0, "rc_rd1_again");

    // Interrupt.
    irq_mask = 6'h04;
    sample(8'h01, 1);
    tick(); tick();
    check("irq_masked", {31'b0, irq}, 32'h0);
    sample(8'h04, 1);
    check("irq_edge1", {31'b0, irq}, 32'h0);
    tick();
    check("irq_edge2", {31'b0, irq}, 32'h1);
    clr = 1'b1; in_valid = 1'b1; status = 8'h04;
    tick();
    clr = 1'b0; in_valid = 1'b0; status = 8'h00;
    check("irq_clr_iv_sticky", {26'b0, sticky}, 32'h04);
    check("irq_clr_iv_irq", {31'b0, irq}, 32'h1);
    pulse_clr();
    check("irq_after_clr", {31'b0, irq}, 32'h1);
    tick();
    check("irq_drop_clr", {31'b0, irq}, 32'h0);
    sample(8'h04, 1);
    tick();
    check("irq_rearm", {31'b0, irq}, 32'h1);
    irq_mask = 6'h00;
    tick();
    check("irq_drop_mask", {31'b0, irq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
